// File: rtl/full_adder.sv
// full_adder: 1-bit full adder slice with generate/propagate and registered sum/carry.
// Optional arithmetic self-check of {Cout,Sum} is built in when FA_SELFCHECK_EN is defined.
module full_adder (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout,
  output logic G,
  output logic P,
  output logic Sum_q,
  output logic Cout_q,
  output logic err
);
  logic t;
  // Two cascaded half adders: (A,B) -> (P,G), then (P,Cin) -> (Sum,t)
  assign P    = A ^ B;
  assign G    = A & B;
  assign Sum  = P ^ Cin;
  assign t    = P & Cin;
  assign Cout = G | t;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      Sum_q  <= 1'b0;
      Cout_q <= 1'b0;
    end else begin
      Sum_q  <= Sum;
      Cout_q <= Cout;
    end
`ifdef FA_SELFCHECK_EN
  logic [1:0] ref_sum;
  assign ref_sum = {1'b0, A} + {1'b0, B} + {1'b0, Cin};
  always_ff @(posedge clk or posedge rst)
    if (rst) err <= 1'b0;
    else if ({Cout, Sum} != ref_sum) err <= 1'b1;
`ifndef SYNTHESIS
  always @(posedge clk)
    if (!rst && ({Cout, Sum} != ref_sum))
      $error("full_adder self-check: {Cout,Sum}=%b expected %b", {Cout, Sum}, ref_sum);
`endif
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: scoreboard bench; stimulus queues expectations, monitor compares on each observe event.
module tb_full_adder;
  logic clk = 1'b0, run = 1'b0;
  logic rst, A, B, Cin;
  logic Sum, Cout, G, P, Sum_q, Cout_q, err;
  int compared = 0, mismatched = 0;

  typedef struct {
    string    name;
    int       kind;
    logic [1:0] exp;
  } exp_t;
  exp_t sb[$];
  event obs;

  full_adder dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .Cin(Cin),
    .Sum(Sum), .Cout(Cout), .G(G), .P(P),
    .Sum_q(Sum_q), .Cout_q(Cout_q), .err(err)
  );

  always #5 clk = run ? ~clk : 1'b0;

  // kind 0: {Cout,Sum}  1: {G,P}  2: {Cout_q,Sum_q}  3: {1'b0,err}
  initial forever begin
    @(obs);
    while (sb.size() > 0) begin
      exp_t e;
      logic [1:0] got;
      e = sb.pop_front();
      got = e.kind == 0 ? {Cout, Sum} : e.kind == 1 ? {G, P} :
            e.kind == 2 ? {Cout_q, Sum_q} : {1'b0, err};
      compared++;
      if (got !== e.exp) begin
        mismatched++;
        $display("FAIL %s: got %b expected %b at %0t", e.name, got, e.exp, $time);
      end
    end
  end

  task automatic expect_v(input string name, input int kind, input logic [1:0] exp);
    exp_t e;
    e.name = name; e.kind = kind; e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic observe();
    #1 -> obs;
    #0;
  endtask

  logic [1:0] tt [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

  initial begin
    rst = 1'b0; A = 1'b0; B = 1'b0; Cin = 1'b0;
    #1 rst = 1'b1;
    expect_v("reset_regs", 2, 2'b00);
    expect_v("reset_err", 3, 2'b00);
    observe();
    for (int i = 0; i < 8; i++) begin
      {A, B, Cin} = i[2:0];
      expect_v($sformatf("sweep_%0d%0d%0d", A, B, Cin), 0, tt[i]);
      observe();
      #9;
    end
    {A, B, Cin} = 3'b110; expect_v("gp_11", 1, 2'b10); observe(); #9;
    {A, B, Cin} = 3'b100; expect_v("gp_10", 1, 2'b01); observe(); #9;
    {A, B, Cin} = 3'b000; expect_v("gp_00", 1, 2'b00); observe(); #9;
    rst = 1'b0;
    {A, B, Cin} = 3'b111;
    expect_v("pre_edge_hold", 2, 2'b00);
    observe();
    run = 1'b1;
    @(posedge clk);
    expect_v("reg_111", 2, 2'b11);
    expect_v("comb_111", 0, 2'b11);
    observe();
    #2 rst = 1'b1;
    expect_v("async_rst_regs", 2, 2'b00);
    expect_v("async_rst_err", 3, 2'b00);
    expect_v("async_rst_comb", 0, 2'b11);
    observe();
    @(posedge clk);
    expect_v("rst_held_regs", 2, 2'b00);
    observe();
    @(negedge clk);
    rst = 1'b0; {A, B, Cin} = 3'b010;
    @(posedge clk);
    expect_v("release_010", 2, 2'b01);
    observe();
    @(negedge clk);
    {A, B, Cin} = 3'b101;
    expect_v("hold_before_edge", 2, 2'b01);
    observe();
    @(posedge clk);
    expect_v("reg_101", 2, 2'b10);
    observe();
    @(negedge clk);
    {A, B, Cin} = 3'b000;
    @(posedge clk);
    expect_v("reg_000", 2, 2'b00);
    observe();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      {A, B, Cin} = i[2:0];
      @(posedge clk);
      expect_v($sformatf("clk_sweep_%0d", i), 2, tt[i]);
      observe();
    end
    expect_v("err_clean", 3, 2'b00);
    observe();
`ifdef FA_SELFCHECK_EN
    @(negedge clk);
    force dut.Sum = ~dut.Sum;
    @(posedge clk);
    #1 release dut.Sum;
    expect_v("err_set", 3, 2'b01);
    observe();
    @(posedge clk);
    expect_v("err_sticky", 3, 2'b01);
    observe();
    rst = 1'b1;
    expect_v("err_cleared", 3, 2'b00);
    observe();
    rst = 1'b0;
`endif
    run = 1'b0;
    #5;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d left expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
